// File: rtl/memory_responder.sv
// Memory responder: services level-held MEM_EN requests after a fixed latency
// and completes them with an active-low MFC four-phase handshake.
module memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MEM_EN,
  input  logic              MEM_RW,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_DIN,
  output logic [DATA_W-1:0] MEM_DOUT,
  output logic              MFC,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // Handshake: a request is MEM_EN sampled high in IDLE; it completes when MFC
  // goes low and is released by MEM_EN going low, after which MFC returns high.
  state_t            state;
  logic [3:0]        cnt;
  logic              cap_rw;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_din;
  logic              finish_now;

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  assign finish_now = (state == ACCESS) && MEM_EN && (cnt == 4'd0);

  // Array has no reset so contents survive reset; a pending write never
  // commits because reset forces state out of ACCESS immediately.
  always_ff @(posedge clk) begin
    if (finish_now && !cap_rw) begin
      mem[cap_addr] <= cap_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      cap_rw   <= 1'b0;
      cap_addr <= '0;
      cap_din  <= '0;
      MEM_DOUT <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MEM_EN) begin
            state    <= ACCESS;
            cnt      <= CNT_INIT;
            cap_rw   <= MEM_RW;
            cap_addr <= MEM_ADDR;
            cap_din  <= MEM_DIN;
          end
        end
        ACCESS: begin
          if (!MEM_EN) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd0) begin
            state <= COMPLETE;
            if (cap_rw) begin
              MEM_DOUT <= mem[cap_addr];
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        COMPLETE: begin
          if (!MEM_EN) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MFC       = (state != COMPLETE);
  assign busy      = (state == ACCESS) || (state == COMPLETE);
  assign state_dbg = state;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: three instances at LATENCY 3, 1 and 15,
// each with its own request signals and a shared clock and reset.
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  en = 3'b000;
  logic [2:0]  rw = 3'b000;
  logic [7:0]  addr [3];
  logic [15:0] din  [3];
  logic [15:0] dout [3];
  logic [2:0]  mfc;
  logic [2:0]  busy;
  logic [1:0]  st   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .MEM_EN(en[0]), .MEM_RW(rw[0]), .MEM_ADDR(addr[0]),
    .MEM_DIN(din[0]), .MEM_DOUT(dout[0]), .MFC(mfc[0]), .busy(busy[0]), .state_dbg(st[0]));
  memory_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .MEM_EN(en[1]), .MEM_RW(rw[1]), .MEM_ADDR(addr[1]),
    .MEM_DIN(din[1]), .MEM_DOUT(dout[1]), .MFC(mfc[1]), .busy(busy[1]), .state_dbg(st[1]));
  memory_responder #(.ADDR_W(8), .DATA_W(16), .LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .MEM_EN(en[2]), .MEM_RW(rw[2]), .MEM_ADDR(addr[2]),
    .MEM_DIN(din[2]), .MEM_DOUT(dout[2]), .MFC(mfc[2]), .busy(busy[2]), .state_dbg(st[2]));

  // ---------------- driver tasks ----------------
  task automatic start_req(input int d, input logic r, input logic [7:0] a, input logic [15:0] wd);
    @(negedge clk);
    en[d] = 1'b1; rw[d] = r; addr[d] = a; din[d] = wd;
    @(posedge clk); #1;  // acceptance edge
  endtask

  task automatic wait_mfc(input int d, output int lat);
    lat = 0;
    while (mfc[d] !== 1'b0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (mfc[d] !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL mfc_timeout dut%0d: MFC=%b after %0d edges, required 0", d, mfc[d], lat);
    end
  endtask

  task automatic end_req(input int d);
    en[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic xfer(input int d, input logic r, input logic [7:0] a, input logic [15:0] wd,
                      output int lat, output logic [15:0] rd);
    start_req(d, r, a, wd);
    wait_mfc(d, lat);
    rd = dout[d];
    end_req(d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (mfc[d] !== 1'b1 || busy[d] !== 1'b0 || dout[d] !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: mfc=%b busy=%b dout=%h, required 1 0 0000",
                 d, mfc[d], busy[d], dout[d]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat;
    logic [15:0] rd;
    xfer(0, 1'b0, 8'h12, 16'hBEEF, lat, rd);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d required 3", lat); end
    start_req(0, 1'b1, 8'h12, 16'h0000);
    wait_mfc(0, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d required 3", lat); end
    n_checks++;
    if (dout[0] !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %h required beef", dout[0]); end
    n_checks++;
    if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_complete: got %b required 1", busy[0]); end
    end_req(0);
    n_checks++;
    if (mfc[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL release: mfc=%b busy=%b required 1 0", mfc[0], busy[0]);
    end
  endtask

  task automatic test_capture();
    int lat;
    logic [15:0] rd;
    xfer(0, 1'b0, 8'h06, 16'h0BAD, lat, rd);
    xfer(0, 1'b1, 8'h06, 16'h0000, lat, rd);
    start_req(0, 1'b0, 8'h05, 16'h1234);
    @(posedge clk); #1;
    addr[0] = 8'h06; din[0] = 16'hFFFF;
    wait_mfc(0, lat);
    end_req(0);
    n_checks++;
    if (dout[0] !== 16'h0BAD) begin n_fail++; $display("FAIL dout_after_write: got %h required 0bad", dout[0]); end
    xfer(0, 1'b1, 8'h05, 16'h0000, lat, rd);
    n_checks++;
    if (rd !== 16'h1234) begin n_fail++; $display("FAIL capture_addr05: got %h required 1234", rd); end
    xfer(0, 1'b1, 8'h06, 16'h0000, lat, rd);
    n_checks++;
    if (rd !== 16'h0BAD) begin n_fail++; $display("FAIL capture_addr06: got %h required 0bad", rd); end
    xfer(0, 1'b0, 8'h06, 16'hC0DE, lat, rd);
    n_checks++;
    if (dout[0] !== 16'h0BAD) begin n_fail++; $display("FAIL write_same_addr_dout: got %h required 0bad", dout[0]); end
  endtask

  task automatic test_abort();
    int lat;
    logic [15:0] rd;
    logic saw_low;
    xfer(0, 1'b0, 8'h20, 16'hAAAA, lat, rd);
    start_req(0, 1'b0, 8'h20, 16'h5555);
    @(posedge clk); #1;
    saw_low = (mfc[0] === 1'b0);
    en[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mfc[0] === 1'b0) saw_low = 1'b1;
    end
    n_checks++;
    if (saw_low !== 1'b0) begin n_fail++; $display("FAIL abort_mfc: MFC went 0, required stay 1"); end
    n_checks++;
    if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b required 0", busy[0]); end
    n_checks++;
    if (dout[0] !== 16'h0BAD) begin n_fail++; $display("FAIL abort_dout: got %h required 0bad", dout[0]); end
    xfer(0, 1'b1, 8'h20, 16'h0000, lat, rd);
    n_checks++;
    if (rd !== 16'hAAAA) begin n_fail++; $display("FAIL abort_mem: got %h required aaaa", rd); end
  endtask

  task automatic test_held();
    int lat;
    int bad;
    start_req(0, 1'b1, 8'h12, 16'h0000);
    wait_mfc(0, lat);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mfc[0] !== 1'b0 || busy[0] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL held_en: %0d cycles left COMPLETE, required 0", bad); end
    end_req(0);
    n_checks++;
    if (mfc[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL held_release: mfc=%b busy=%b required 1 0", mfc[0], busy[0]);
    end
    n_checks++;
    if (dout[0] !== 16'hBEEF) begin n_fail++; $display("FAIL held_data: got %h required beef", dout[0]); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] rd;
    xfer(0, 1'b0, 8'h30, 16'h1111, lat, rd);
    xfer(0, 1'b1, 8'h30, 16'h0000, lat, rd);
    n_checks++;
    if (rd !== 16'h1111) begin n_fail++; $display("FAIL pre_reset_read: got %h required 1111", rd); end
    start_req(0, 1'b0, 8'h30, 16'h7777);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks++;
    if (mfc[0] !== 1'b1 || busy[0] !== 1'b0 || dout[0] !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset: mfc=%b busy=%b dout=%h required 1 0 0000", mfc[0], busy[0], dout[0]);
    end
    rw[0] = 1'b1;  // MEM_EN stays high through reset release
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    wait_mfc(0, lat);
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d required 3", lat); end
    n_checks++;
    if (dout[0] !== 16'h1111) begin n_fail++; $display("FAIL reset_discard: got %h required 1111", dout[0]); end
    end_req(0);
  endtask

  task automatic test_sweep();
    int lat;
    int exp_lat;
    logic [15:0] rd;
    logic [15:0] v0;
    logic [15:0] vf;
    for (int d = 1; d < 3; d++) begin
      exp_lat = (d == 1) ? 1 : 15;
      v0 = (d == 1) ? 16'h0F0F : 16'h3C3C;
      vf = (d == 1) ? 16'hF0F0 : 16'hC3C3;
      xfer(d, 1'b0, 8'h00, v0, lat, rd);
      n_checks++;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL sweep_wr_lat dut%0d: got %0d required %0d", d, lat, exp_lat); end
      xfer(d, 1'b0, 8'hFF, vf, lat, rd);
      xfer(d, 1'b1, 8'h00, 16'h0000, lat, rd);
      n_checks++;
      if (lat !== exp_lat) begin n_fail++; $display("FAIL sweep_rd_lat dut%0d: got %0d required %0d", d, lat, exp_lat); end
      n_checks++;
      if (rd !== v0) begin n_fail++; $display("FAIL sweep_addr00 dut%0d: got %h required %h", d, rd, v0); end
      xfer(d, 1'b1, 8'hFF, 16'h0000, lat, rd);
      n_checks++;
      if (rd !== vf) begin n_fail++; $display("FAIL sweep_addrff dut%0d: got %h required %h", d, rd, vf); end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      addr[d] = 8'h00;
      din[d]  = 16'h0000;
    end
    test_reset();
    test_write_read();
    test_capture();
    test_abort();
    test_held();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_W, default 8, address width; memory depth is 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16, data word width.
REQ-003 Parameter LATENCY, default 3, access latency in clk cycles; legal range 1..15.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 MEM_EN  input  1  request strobe from the fetch/execute controller; level-held for the whole access.
REQ-007 MEM_RW  input  1  access type: 1 = read, 0 = write.
REQ-008 MEM_ADDR  input  ADDR_W  word address.
REQ-009 MEM_DIN  input  DATA_W  write data from MDR.
REQ-010 MEM_DOUT  output  DATA_W  read data to MDR.
REQ-011 MFC  output  1  memory-function-complete, active-low: 0 = access complete, 1 = not complete.
REQ-012 busy  output  1  1 while an access is in progress (ACCESS or COMPLETE).

Function
REQ-013 The block SHALL implement a Moore FSM with states IDLE, ACCESS, COMPLETE; MFC and busy SHALL be decoded from the registered state only.
REQ-014 IDLE: MFC=1, busy=0; MEM_EN sampled 1 -> ACCESS, capturing MEM_RW, MEM_ADDR, MEM_DIN into internal registers and loading the latency counter with LATENCY-1.
REQ-015 ACCESS: MFC=1, busy=1; counter decrements each cycle; with counter==0 and MEM_EN==1 -> COMPLETE.
REQ-016 On the ACCESS->COMPLETE edge, a captured write SHALL store the captured data at the captured address, and a captured read SHALL load MEM_DOUT from the captured address.
REQ-017 MFC SHALL first read 0 exactly LATENCY rising edges after the edge at which MEM_EN was sampled 1 in IDLE.
REQ-018 COMPLETE: MFC=0, busy=1; held while MEM_EN==1; MEM_EN sampled 0 -> IDLE (MFC returns to 1 the following cycle).
REQ-019 Changes on MEM_RW, MEM_ADDR, MEM_DIN after capture SHALL have no effect on the access in progress.
REQ-020 MEM_DOUT SHALL hold its value from a read completion until the next read completion; writes SHALL NOT alter MEM_DOUT, even when the write targets the address last read.
REQ-021 Abort: MEM_EN sampled 0 in ACCESS -> IDLE; the memory array and MEM_DOUT SHALL remain unchanged and MFC SHALL never go 0 for that access.
REQ-022 A new request SHALL be accepted only in IDLE; MEM_EN held high across COMPLETE SHALL NOT start a second access (four-phase handshake: MEM_EN must drop and MFC return to 1 first).
REQ-023 The minimum back-to-back spacing SHALL be: MEM_EN low sampled in COMPLETE, IDLE one cycle, then the next request is accepted on the following edge.
REQ-024 Address wrap is not applicable: every ADDR_W-bit value SHALL address a valid word, 0 through 2**ADDR_W-1.
REQ-025 Illegal state encodings SHALL return to IDLE on the next edge.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, MFC=1, busy=0, MEM_DOUT=0, latency counter=0, and clear the captured request registers.
REQ-027 Reset SHALL NOT clear the memory array; contents are undefined after power-up and preserved across reset, except that a write pending in ACCESS when reset asserts SHALL be discarded.
REQ-028 After reset deasserts, a MEM_EN already high SHALL be treated as a new request on the first rising edge.

Verification
REQ-029 Write then read, LATENCY=3: write 0xBEEF to address 0x12 and complete the handshake; then read 0x12 -> MFC=0 exactly 3 edges after acceptance, MEM_DOUT=0xBEEF, busy=1 until MEM_EN drops.
REQ-030 Capture isolation: write 0x1234 to 0x05, and change MEM_ADDR to 0x06 and MEM_DIN to 0xFFFF one cycle after acceptance -> read of 0x05 returns 0x1234; address 0x06 is unchanged.
REQ-031 Abort: write 0xAAAA to 0x20 and complete it; then start a write of 0x5555 to 0x20 and drop MEM_EN after 1 ACCESS cycle -> MFC stays 1 throughout; a subsequent read of 0x20 returns 0xAAAA.
REQ-032 Held MEM_EN: keep MEM_EN=1 for 10 cycles after MFC=0 -> exactly one access, MFC stays 0 and busy stays 1; after MEM_EN drops, MFC=1 and busy=0 within 1 cycle.
REQ-033 Reset mid-access: assert reset during ACCESS of a write of 0x7777 to 0x30, after a prior write of 0x1111 to 0x30 -> MFC=1, busy=0, MEM_DOUT=0 immediately; a subsequent read of 0x30 returns 0x1111.
REQ-034 Boundary and latency sweep: with LATENCY=1 and LATENCY=15, write and read addresses 0x00 and 0xFF -> data matches, and MFC=0 occurs exactly LATENCY edges after acceptance.
